frac_pixel_sched: RTL
=====================

Name: frac_pixel_sched

Overview:
- Frame-level scheduler for a bank of NU fractal iteration units.
- Walks an H×V pixel grid and generates each pixel's complex coordinate (cx, cy) incrementally from a start point and per-pixel steps.
- Dispatches pixels to whichever unit is free; collects each unit's done/found result; emits one frame-buffer write per finished pixel.
- Sits between the host/config registers and the unit array, upstream of the frame-buffer write port.

Parameters:
- N, 32, coordinate width (two's-complement fixed point, format untouched here).
- NU, 4, number of iteration units served (1..8).
- AW, 19, pixel address width; H_SIZE×V_SIZE must not exceed 2^AW.

Ports:
- frac_clk  in  1  clock.
- frac_rst  in  1  asynchronous, active-high reset.
- sched_start  in  1  start-frame pulse; ignored while sched_busy=1.
- sched_x0, sched_y0  in  N  coordinate of pixel (0,0).
- sched_dx, sched_dy  in  N  column / row step.
- sched_h_size, sched_v_size  in  12  columns / rows; each ≥1.
- sched_max_iter  in  16  iteration limit passed to every unit.
- sched_busy  out  1  frame in progress.
- sched_done_tick  out  1  one-cycle pulse when the last result is written.
- unit_cx, unit_cy  out  NU*N  per-unit coordinate; slice k belongs to unit k.
- unit_max_iter  out  16  shared iteration limit.
- unit_go  out  NU  one-hot go pulse.
- unit_done_tick  in  NU  per-unit completion pulse.
- unit_found  in  NU  per-unit result; valid when its done_tick=1.
- fb_we  out  1  frame-buffer write strobe.
- fb_addr  out  AW  linear address = row*h_size+col.
- fb_data  out  1  found bit.

Behaviour:
- Reset values: all outputs 0; state IDLE; all occupied/pending flags cleared.
- State IDLE:
  - On sched_start: latch all config inputs, col=row=addr=0, cx=x0, cy=y0, sched_busy=1 (next cycle) -> DISPATCH.
- State DISPATCH, each cycle:
  - Select the lowest-index unit k with occ[k]=0 and pend[k]=0.
  - If such a unit exists: unit_go[k]=1 for one cycle; drive unit_cx/unit_cy slice k with the current cx/cy, held until the next go to k; set tag[k]=addr and occ[k]=1.
  - Advance the pixel: if col==h_size-1 then col=0, cx=x0, cy+=dy, row++; else col++, cx+=dx. addr++.
  - Additions are N-bit and wrap modulo 2^N; no saturation.
  - After the go for the last pixel (row==v_size-1, col==h_size-1) -> DRAIN.
  - At most one go per cycle.
- Unit occupancy is tracked internally; unit_busy is not used.
  - The unit samples go in its idle state and starts busy one cycle later, so the scheduler must not rely on it.
- Result collection (DISPATCH and DRAIN):
  - unit_done_tick[k] sets pend[k]=1, captures found into res[k], and clears occ[k] in the same cycle.
  - Write arbiter: lowest-index pending unit j drives fb_we=1, fb_addr=tag[j], fb_data=res[j], and clears pend[j]. One write per cycle; writes may be out of address order.
  - Simultaneous done_ticks are all captured; they are written on consecutive cycles.
  - A unit is not redispatched until its pending result is written.
  - Result latency: fb_we occurs 1 cycle after done_tick if uncontested, otherwise ≤NU cycles.
- State DRAIN: when all occ=0 and all pend=0, pulse sched_done_tick, sched_busy=0 -> IDLE.
- Frame sizes:
  - 1×1 frame: dispatch exactly one pixel, enter DRAIN immediately.
  - h_size=1: every pixel is a row wrap.
- sched_start while busy: ignored, no config change.
- Reset mid-frame: immediate abort, no further go/we. Units must be reset by the same reset.
- unit_max_iter is driven from the latched value for the whole frame.

Optional Feature:
- Macro FRAC_SCHED_PERF_EN.
- Defined:
  - Adds output sched_cycles (32), counting frac_clk cycles from start accept to sched_done_tick inclusive. Cleared on start and on reset, held after done.
  - Adds output sched_found_cnt (AW+1), counting writes with fb_data=1. Cleared on start and on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- NU=4, 4×2 frame, x0=y0=0, dx=1, dy=2 (raw), unit models with fixed 5-cycle latency, found=1 -> 8 gos in order addr 0..7; cx=0,1,2,3,0,1,2,3; cy=0×4 then 2×4; 8 fb_we all data=1; one sched_done_tick; busy low afterward.
- All 4 units return done_tick in the same cycle with found=1,0,1,0 -> 4 consecutive fb_we, units 0..3 in order, tags and data correct; no unit redispatched before its write.
- 1×1 frame -> exactly one unit_go, one fb_we to addr 0, done_tick 1 cycle after the write.
- Random unit latencies 1..20 on a 16×16 frame -> each addr 0..255 written exactly once with the model's found value; go never issued to an occupied unit.
- sched_start asserted mid-frame with different x0 -> ignored; the frame completes with the original coordinates.
- frac_rst asserted mid-frame -> all outputs 0 asynchronously; a fresh start after release runs a complete frame; with FRAC_SCHED_PERF_EN, sched_cycles and sched_found_cnt read 0 after reset.

Source files
------------

// File: rtl/frac_pixel_sched.sv
// Frame scheduler: walks an H x V pixel grid, dispatches coordinates to NU fractal units and
// turns their results into frame-buffer writes. Define FRAC_SCHED_PERF_EN for cycle/found counters.
module frac_pixel_sched #(
    parameter int N  = 32,
    parameter int NU = 4,
    parameter int AW = 19
) (
    input  logic                 frac_clk,
    input  logic                 frac_rst,
    input  logic                 sched_start,
    input  logic signed [N-1:0]  sched_x0,
    input  logic signed [N-1:0]  sched_y0,
    input  logic signed [N-1:0]  sched_dx,
    input  logic signed [N-1:0]  sched_dy,
    input  logic [11:0]          sched_h_size,
    input  logic [11:0]          sched_v_size,
    input  logic [15:0]          sched_max_iter,
    output logic                 sched_busy,
    output logic                 sched_done_tick,
    output logic [NU*N-1:0]      unit_cx,
    output logic [NU*N-1:0]      unit_cy,
    output logic [15:0]          unit_max_iter,
    output logic [NU-1:0]        unit_go,
    input  logic [NU-1:0]        unit_done_tick,
    input  logic [NU-1:0]        unit_found,
    output logic                 fb_we,
    output logic [AW-1:0]        fb_addr,
    output logic                 fb_data
`ifdef FRAC_SCHED_PERF_EN
    ,
    output logic [31:0]          sched_cycles,
    output logic [AW:0]          sched_found_cnt
`endif
);

    localparam int IW = (NU > 1) ? $clog2(NU) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN} state_t;

    state_t              state_q;
    logic signed [N-1:0] x0_q, dx_q, dy_q;
    logic [11:0]         h_q, v_q, col_q, row_q;
    logic [AW-1:0]       addr_q;
    logic signed [N-1:0] cx_q, cy_q;
    logic [15:0]         max_iter_q;
    logic [NU-1:0]       occ_q, pend_q, res_q, go_q;
    logic [AW-1:0]       tag_q [NU];
    logic [NU*N-1:0]     ucx_q, ucy_q;
    logic                busy_q, done_q, we_q, wdata_q;
    logic [AW-1:0]       waddr_q;
`ifdef FRAC_SCHED_PERF_EN
    logic [31:0]         cycles_q;
    logic [AW:0]         found_cnt_q;
`endif

    logic [NU-1:0]       done_v, res_d, free, go_d, pend_d, occ_d;
    logic                free_vld, wr_vld, accept, dispatch, col_last, last_px;
    logic [IW-1:0]       free_idx, wr_idx;

    always_comb begin
        // Done ticks from idle units are ignored; incoming results join the write arbitration
        // in the same cycle so an uncontested result is written one cycle after its tick.
        done_v   = unit_done_tick & occ_q;
        res_d    = (unit_found & done_v) | (res_q & ~done_v);
        free     = ~occ_q & ~pend_q;
        free_vld = 1'b0;
        free_idx = '0;
        wr_vld   = 1'b0;
        wr_idx   = '0;
        for (int k = NU - 1; k >= 0; k--) begin
            if (free[k]) begin
                free_vld = 1'b1;
                free_idx = k[IW-1:0];
            end
            if (pend_q[k] | done_v[k]) begin
                wr_vld = 1'b1;
                wr_idx = k[IW-1:0];
            end
        end
        accept   = (state_q == S_IDLE) && sched_start;
        dispatch = (state_q == S_DISPATCH) && free_vld;
        go_d     = '0;
        if (dispatch) go_d[free_idx] = 1'b1;
        pend_d   = pend_q | done_v;
        if (wr_vld) pend_d[wr_idx] = 1'b0;
        occ_d    = (occ_q & ~done_v) | go_d;
        col_last = (col_q == h_q - 12'd1);
        last_px  = col_last && (row_q == v_q - 12'd1);
    end

    always_ff @(posedge frac_clk or posedge frac_rst) begin
        if (frac_rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            go_q        <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= 1'b0;
            occ_q       <= '0;
            pend_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            max_iter_q  <= '0;
            ucx_q       <= '0;
            ucy_q       <= '0;
`ifdef FRAC_SCHED_PERF_EN
            cycles_q    <= '0;
            found_cnt_q <= '0;
`endif
        end else begin
            go_q   <= go_d;
            we_q   <= wr_vld;
            done_q <= 1'b0;
            occ_q  <= occ_d;
            pend_q <= pend_d;
            if (wr_vld) begin
                waddr_q <= tag_q[wr_idx];
                wdata_q <= res_d[wr_idx];
            end
`ifdef FRAC_SCHED_PERF_EN
            // The done cycle itself is counted, so the final value lands one edge after it.
            if (accept)
                cycles_q <= 32'd1;
            else if (state_q != S_IDLE || done_q)
                cycles_q <= cycles_q + 32'd1;
            if (accept)
                found_cnt_q <= '0;
            else if (wr_vld && res_d[wr_idx])
                found_cnt_q <= found_cnt_q + 1'b1;
`endif
            case (state_q)
                S_IDLE: begin
                    if (sched_start) begin
                        busy_q     <= 1'b1;
                        col_q      <= '0;
                        row_q      <= '0;
                        addr_q     <= '0;
                        cx_q       <= sched_x0;
                        cy_q       <= sched_y0;
                        max_iter_q <= sched_max_iter;
                        state_q    <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (free_vld) begin
                        ucx_q[free_idx*N +: N] <= cx_q;
                        ucy_q[free_idx*N +: N] <= cy_q;
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + 12'd1;
                            cx_q  <= x0_q;
                            cy_q  <= cy_q + dy_q;
                        end else begin
                            col_q <= col_q + 12'd1;
                            cx_q  <= cx_q + dx_q;
                        end
                        addr_q <= addr_q + 1'b1;
                        if (last_px) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (occ_q == '0 && pend_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Frame configuration, pixel tags and captured results carry no reset: they are only
    // consumed after a start or a done tick has rewritten them.
    always_ff @(posedge frac_clk) begin
        res_q <= res_d;
        if (accept) begin
            x0_q <= sched_x0;
            dx_q <= sched_dx;
            dy_q <= sched_dy;
            h_q  <= sched_h_size;
            v_q  <= sched_v_size;
        end
        if (dispatch) tag_q[free_idx] <= addr_q;
    end

    assign sched_busy      = busy_q;
    assign sched_done_tick = done_q;
    assign unit_cx         = ucx_q;
    assign unit_cy         = ucy_q;
    assign unit_max_iter   = max_iter_q;
    assign unit_go         = go_q;
    assign fb_we           = we_q;
    assign fb_addr         = waddr_q;
    assign fb_data         = wdata_q;
`ifdef FRAC_SCHED_PERF_EN
    assign sched_cycles    = cycles_q;
    assign sched_found_cnt = found_cnt_q;
`endif

endmodule
